// File: rtl/geofence_pkg.sv
// Shared definitions for the geofence host driver: state codes, point field layout
// and ROM word unpacking.
package geofence_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StSend  = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam int unsigned POINTS_PER_SET = 6;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned R_W   = 11;
  localparam int unsigned ROM_W = X_W + Y_W + R_W;

  localparam int unsigned R_LSB = 0;
  localparam int unsigned Y_LSB = R_LSB + R_W;
  localparam int unsigned X_LSB = Y_LSB + Y_W;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [R_W-1:0] r;
  } point_t;

  function automatic point_t unpack_word(logic [ROM_W-1:0] w);
    point_t p;
    p.x = w[X_LSB +: X_W];
    p.y = w[Y_LSB +: Y_W];
    p.r = w[R_LSB +: R_W];
    return p;
  endfunction

endpackage

// File: rtl/geofence_point_buf.sv
// Six-entry point buffer holding raw ROM words; synchronous write, combinational read.
module geofence_point_buf
  import geofence_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [ROM_W-1:0] wdata_i,
  input  logic [2:0]       raddr_i,
  output logic [ROM_W-1:0] rdata_o
);

  logic [ROM_W-1:0] mem_q [POINTS_PER_SET];
  logic [ROM_W-1:0] mem_d [POINTS_PER_SET];

  always_comb begin
    mem_d = mem_q;
    if (we_i && (waddr_i < 3'(POINTS_PER_SET))) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < POINTS_PER_SET; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = (raddr_i < 3'(POINTS_PER_SET)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/geofence_driver.sv
// Host-side initiator for the geofence core: fetch each hexagon from ROM, stream its six
// points, wait for the core verdict (or give up), and record the result.
module geofence_driver
  import geofence_pkg::*;
#(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [X_W-1:0]    X,
  output logic [Y_W-1:0]    Y,
  output logic [R_W-1:0]    R,
  input  logic              valid,
  input  logic              is_inside,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [1:0]        res_data,
  output logic [ADDR_W-1:0] inside_cnt,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]  LastSend = 3'(POINTS_PER_SET - 1);
  localparam logic [2:0]  LastFetch = 3'(POINTS_PER_SET);

  logic [2:0]        state_q, state_d;
  logic [2:0]        pt_q, pt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] set_q, set_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [ADDR_W-1:0] inside_cnt_q, inside_cnt_d;
  logic [1:0]        res_data_q, res_data_d;
  logic              res_we_q, res_we_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [R_W-1:0]    r_q, r_d;

  logic              buf_we;
  logic [2:0]        buf_waddr, buf_raddr;
  logic [ROM_W-1:0]  buf_rdata;
  logic              load_pt;
  logic [ADDR_W-1:0] set_base;
  point_t            rd_pt;

  geofence_point_buf u_point_buf (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (rom_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign set_base = set_q * ADDR_W'(POINTS_PER_SET);
  assign rd_pt    = unpack_word(buf_rdata);

  // Points are registered one cycle ahead, so read the entry for the next SEND cycle.
  always_comb begin
    buf_raddr = 3'd0;
    if (state_q == StSend) begin
      buf_raddr = pt_q + 3'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pt_d         = pt_q;
    wait_d       = wait_q;
    set_d        = set_q;
    rom_addr_d   = rom_addr_q;
    res_we_d     = 1'b0;
    res_addr_d   = res_addr_q;
    res_data_d   = res_data_q;
    inside_cnt_d = inside_cnt_q;
    buf_we       = 1'b0;
    buf_waddr    = pt_q - 3'd1;
    load_pt      = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StFetch;
          pt_d         = '0;
          set_d        = '0;
          inside_cnt_d = '0;
          rom_addr_d   = '0;
        end
      end
      StFetch: begin
        // ROM data lags its address by one cycle, so capture trails addressing by one.
        buf_we = (pt_q != 3'd0);
        if (pt_q < LastSend) begin
          rom_addr_d = set_base + ADDR_W'(pt_q) + ADDR_W'(1);
        end
        if (pt_q == LastFetch) begin
          state_d = StSend;
          pt_d    = '0;
          load_pt = 1'b1;
        end else begin
          pt_d = pt_q + 3'd1;
        end
      end
      StSend: begin
        if (pt_q == LastSend) begin
          state_d = StWait;
          wait_d  = '0;
        end else begin
          pt_d    = pt_q + 3'd1;
          load_pt = 1'b1;
        end
      end
      StWait: begin
        if (valid) begin
          state_d    = StWrite;
          res_we_d   = 1'b1;
          res_addr_d = set_q;
          res_data_d = {1'b0, is_inside};
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          state_d    = StWrite;
          res_we_d   = 1'b1;
          res_addr_d = set_q;
          res_data_d = 2'b10;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWrite: begin
        if ((res_data_q == 2'b01) && (inside_cnt_q != ADDR_W'(NUM_SETS))) begin
          inside_cnt_d = inside_cnt_q + ADDR_W'(1);
        end
        set_d = set_q + ADDR_W'(1);
        if (set_q < ADDR_W'(NUM_SETS - 1)) begin
          state_d    = StFetch;
          pt_d       = '0;
          rom_addr_d = (set_q + ADDR_W'(1)) * ADDR_W'(POINTS_PER_SET);
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d = '0;
    y_d = '0;
    r_d = '0;
    if (load_pt) begin
      x_d = rd_pt.x;
      y_d = rd_pt.y;
      r_d = rd_pt.r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pt_q         <= '0;
      wait_q       <= '0;
      set_q        <= '0;
      rom_addr_q   <= '0;
      res_we_q     <= 1'b0;
      res_addr_q   <= '0;
      res_data_q   <= '0;
      inside_cnt_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      r_q          <= '0;
    end else begin
      state_q      <= state_d;
      pt_q         <= pt_d;
      wait_q       <= wait_d;
      set_q        <= set_d;
      rom_addr_q   <= rom_addr_d;
      res_we_q     <= res_we_d;
      res_addr_q   <= res_addr_d;
      res_data_q   <= res_data_d;
      inside_cnt_q <= inside_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      r_q          <= r_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign R          = r_q;
  assign res_we     = res_we_q;
  assign res_addr   = res_addr_q;
  assign res_data   = res_data_q;
  assign inside_cnt = inside_cnt_q;
  assign busy       = (state_q == StFetch) || (state_q == StSend) ||
                      (state_q == StWait) || (state_q == StWrite);
  assign done       = (state_q == StDone);

endmodule
